// File: rtl/multi_mips_controller.sv
// Multicycle MIPS control unit: Moore main FSM plus ALU decoder.
// Drives datapath selects, enables and ALUControl from Opcode/Funct/zero.
module multi_mips_controller #(
    parameter bit EN_ADDI = 1'b1,
    parameter bit EN_JUMP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       zero,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       IorD,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       Branch,
    output logic       PCWrite,
    output logic       PCEn,
    output logic [2:0] ALUControl,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state_q;
    state_t state_d;

    logic       is_lw;
    logic       is_sw;
    logic       is_r;
    logic       is_beq;
    logic       is_addi;
    logic       is_j;
    logic       op_legal;
    logic [2:0] funct_alu;

    assign is_lw    = (Opcode == OP_LW);
    assign is_sw    = (Opcode == OP_SW);
    assign is_r     = (Opcode == OP_R);
    assign is_beq   = (Opcode == OP_BEQ);
    assign is_addi  = EN_ADDI && (Opcode == OP_ADDI);
    assign is_j     = EN_JUMP && (Opcode == OP_J);
    assign op_legal = is_lw | is_sw | is_r | is_beq | is_addi | is_j;

    // State register; reset forces FETCH ahead of any transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; unused codes fall back to FETCH.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                if (is_lw || is_sw) begin
                    state_d = MEMADR;
                end else if (is_r) begin
                    state_d = EXECUTE;
                end else if (is_beq) begin
                    state_d = BRANCH;
                end else if (is_addi) begin
                    state_d = ADDIEXEC;
                end else if (is_j) begin
                    state_d = JUMP;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMADR:   state_d = is_lw ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            EXECUTE:  state_d = ALUWB;
            ADDIEXEC: state_d = ADDIWB;
            default:  state_d = FETCH;
        endcase
    end

    // R-type function field to ALU operation; unknown codes add.
    always_comb begin
        funct_alu = 3'b010;
        case (Funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_alu = 3'b010;
        endcase
    end

    // Moore output decode; anything not set for a state stays 0.
    always_comb begin
        MemToReg   = 1'b0;
        RegDst     = 1'b0;
        IorD       = 1'b0;
        PCSrc      = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        Branch     = 1'b0;
        PCWrite    = 1'b0;
        ALUControl = 3'b000;
        case (state_q)
            FETCH: begin
                IRWrite    = 1'b1;
                PCWrite    = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = 3'b010;
            end
            DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = 3'b010;
            end
            MEMADR, ADDIEXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = 3'b010;
            end
            MEMREAD: IorD = 1'b1;
            MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            MEMWB: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_alu;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            ADDIWB: RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = 3'b110;
                PCSrc      = 2'b01;
                Branch     = 1'b1;
            end
            JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
            default: ALUControl = 3'b000;
        endcase
    end

    assign PCEn      = PCWrite | (Branch & zero);
    assign IllegalOp = (state_q == DECODE) & ~op_legal;
    assign State     = state_q;

endmodule

// File: tb/tb_multi_mips_controller.sv
// Bench for multi_mips_controller: directed checks on two builds
// (all ops enabled / ADDI+J disabled) then randomized model comparison.
module tb_multi_mips_controller;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [5:0] op [2];
    logic [5:0] fn [2];
    logic       z [2];
    logic       m2r [2];
    logic       rdst [2];
    logic       iord [2];
    logic [1:0] pcs [2];
    logic       asa [2];
    logic [1:0] asb [2];
    logic       irw [2];
    logic       mw [2];
    logic       rw [2];
    logic       br [2];
    logic       pcw [2];
    logic       pcen [2];
    logic [2:0] alu [2];
    logic       ill [2];
    logic [3:0] st [2];

    int checks = 0;
    int errors = 0;

    multi_mips_controller #(.EN_ADDI(1'b1), .EN_JUMP(1'b1)) u0 (
        .clk(clk), .reset(reset), .Opcode(op[0]), .Funct(fn[0]),
        .zero(z[0]), .MemToReg(m2r[0]), .RegDst(rdst[0]),
        .IorD(iord[0]), .PCSrc(pcs[0]), .ALUSrcA(asa[0]),
        .ALUSrcB(asb[0]), .IRWrite(irw[0]), .MemWrite(mw[0]),
        .RegWrite(rw[0]), .Branch(br[0]), .PCWrite(pcw[0]),
        .PCEn(pcen[0]), .ALUControl(alu[0]), .IllegalOp(ill[0]),
        .State(st[0])
    );

    multi_mips_controller #(.EN_ADDI(1'b0), .EN_JUMP(1'b0)) u1 (
        .clk(clk), .reset(reset), .Opcode(op[1]), .Funct(fn[1]),
        .zero(z[1]), .MemToReg(m2r[1]), .RegDst(rdst[1]),
        .IorD(iord[1]), .PCSrc(pcs[1]), .ALUSrcA(asa[1]),
        .ALUSrcB(asb[1]), .IRWrite(irw[1]), .MemWrite(mw[1]),
        .RegWrite(rw[1]), .Branch(br[1]), .PCWrite(pcw[1]),
        .PCEn(pcen[1]), .ALUControl(alu[1]), .IllegalOp(ill[1]),
        .State(st[1])
    );

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic stp(input logic [3:0] e0, input logic [3:0] e1);
        @(negedge clk);
        #1;
        chk("state_en", {28'd0, st[0]}, {28'd0, e0});
        chk("state_dis", {28'd0, st[1]}, {28'd0, e1});
    endtask

    task automatic setop(input logic [5:0] o, input logic [5:0] f,
                         input logic zz);
        for (int d = 0; d < 2; d++) begin
            op[d] = o;
            fn[d] = f;
            z[d]  = zz;
        end
    endtask

    function automatic bit legal(input logic [5:0] o, input bit en);
        return (o == LW) || (o == SW) || (o == RT) || (o == BEQ) ||
               (en && (o == ADDI)) || (en && (o == JMP));
    endfunction

    function automatic logic [2:0] fdec(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected output bundle from the per-state table of the control unit.
    function automatic logic [21:0] model(input int s, input logic [5:0] o,
                                          input logic [5:0] f,
                                          input logic zz, input bit en);
        logic e_m2r, e_rdst, e_iord, e_asa, e_irw, e_mw, e_rw, e_br;
        logic e_pcw, e_pcen, e_ill;
        logic [1:0] e_pcs, e_asb;
        logic [2:0] e_alu;
        {e_m2r, e_rdst, e_iord, e_asa, e_irw, e_mw} = '0;
        {e_rw, e_br, e_pcw} = '0;
        e_pcs = 2'b00;
        e_asb = 2'b00;
        e_alu = 3'b000;
        case (s)
            0: begin e_irw = 1; e_pcw = 1; e_asb = 2'b01; e_alu = 3'b010; end
            1: begin e_asb = 2'b11; e_alu = 3'b010; end
            2, 9: begin e_asa = 1; e_asb = 2'b10; e_alu = 3'b010; end
            3: e_iord = 1;
            4: begin e_m2r = 1; e_rw = 1; end
            5: begin e_iord = 1; e_mw = 1; end
            6: begin e_asa = 1; e_alu = fdec(f); end
            7: begin e_rdst = 1; e_rw = 1; end
            8: begin e_asa = 1; e_alu = 3'b110; e_pcs = 2'b01; e_br = 1; end
            10: e_rw = 1;
            11: begin e_pcs = 2'b10; e_pcw = 1; end
            default: e_alu = 3'b000;
        endcase
        e_pcen = e_pcw | (e_br & zz);
        e_ill  = (s == 1) && !legal(o, en);
        return {e_m2r, e_rdst, e_iord, e_pcs, e_asa, e_asb, e_irw, e_mw,
                e_rw, e_br, e_pcw, e_pcen, e_alu, e_ill, s[3:0]};
    endfunction

    function automatic logic [21:0] actv(input int d);
        return {m2r[d], rdst[d], iord[d], pcs[d], asa[d], asb[d], irw[d],
                mw[d], rw[d], br[d], pcw[d], pcen[d], alu[d], ill[d], st[d]};
    endfunction

    logic [3:0] lw_seq [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [3:0] sw_seq [4] = '{4'd1, 4'd2, 4'd5, 4'd0};
    logic [5:0] r_fn [3]   = '{6'b100010, 6'b101010, 6'b000000};
    logic [2:0] r_alu [3]  = '{3'b110, 3'b111, 3'b010};
    logic [5:0] fn_pool [6] = '{6'b100000, 6'b100010, 6'b100100,
                                6'b100101, 6'b101010, 6'b000111};

    int q [2][$];
    int e [2];

    initial begin
        reset = 1'b1;
        setop(LW, 6'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_state", {28'd0, st[0]}, 32'd0);
        chk("rst_irw", {31'd0, irw[0]}, 32'd1);
        chk("rst_pcw", {31'd0, pcw[0]}, 32'd1);
        chk("rst_asb", {30'd0, asb[0]}, 32'd1);
        chk("rst_alu", {29'd0, alu[0]}, 32'd2);
        chk("rst_pcen", {31'd0, pcen[0]}, 32'd1);
        chk("rst_rw", {31'd0, rw[0]}, 32'd0);
        reset = 1'b0;

        foreach (lw_seq[i]) begin
            stp(lw_seq[i], lw_seq[i]);
            chk("lw_mw", {31'd0, mw[0]}, 32'd0);
            if (lw_seq[i] == 4'd4) begin
                chk("lw_rw", {31'd0, rw[0]}, 32'd1);
                chk("lw_m2r", {31'd0, m2r[0]}, 32'd1);
            end
        end

        setop(BEQ, 6'd0, 1'b1);
        stp(1, 1);
        stp(8, 8);
        chk("beq_z1_pcen", {31'd0, pcen[0]}, 32'd1);
        stp(0, 0);
        setop(BEQ, 6'd0, 1'b0);
        stp(1, 1);
        stp(8, 8);
        chk("beq_z0_pcen", {31'd0, pcen[0]}, 32'd0);
        stp(0, 0);

        foreach (r_fn[i]) begin
            setop(RT, r_fn[i], 1'b0);
            stp(1, 1);
            stp(6, 6);
            chk("r_alu", {29'd0, alu[0]}, {29'd0, r_alu[i]});
            stp(7, 7);
            chk("r_rdst", {31'd0, rdst[0]}, 32'd1);
            chk("r_rw", {31'd0, rw[0]}, 32'd1);
            stp(0, 0);
        end

        setop(SW, 6'd0, 1'b0);
        foreach (sw_seq[i]) begin
            stp(sw_seq[i], sw_seq[i]);
            chk("sw_mw", {31'd0, mw[0]}, {31'd0, sw_seq[i] == 4'd5});
            chk("sw_iord", {31'd0, iord[0]}, {31'd0, sw_seq[i] == 4'd5});
            chk("sw_rw", {31'd0, rw[0]}, 32'd0);
        end

        setop(6'b111111, 6'd0, 1'b0);
        stp(1, 1);
        chk("bad_ill", {30'd0, ill[0], ill[1]}, 32'd3);
        stp(0, 0);

        setop(ADDI, 6'd0, 1'b0);
        stp(1, 1);
        chk("addi_ill", {30'd0, ill[0], ill[1]}, 32'd1);
        stp(9, 0);
        chk("addi_asb", {30'd0, asb[0]}, 32'd2);
        stp(10, 1);
        chk("addi_rw", {31'd0, rw[0]}, 32'd1);
        stp(0, 0);

        setop(LW, 6'd0, 1'b0);
        stp(1, 1);
        stp(2, 2);
        stp(3, 3);
        reset = 1'b1;
        stp(0, 0);
        chk("abort_rw", {31'd0, rw[0]}, 32'd0);
        reset = 1'b0;
        setop(JMP, 6'd0, 1'b0);
        stp(1, 1);
        chk("j_ill", {30'd0, ill[0], ill[1]}, 32'd1);
        chk("j_dis_en", {29'd0, rw[1], mw[1], pcw[1]}, 32'd0);
        stp(11, 0);
        chk("j_pcs", {30'd0, pcs[0]}, 32'd2);
        chk("j_pcen", {31'd0, pcen[0]}, 32'd1);

        reset = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit rs;
            @(negedge clk);
            rs = reset;
            for (int d = 0; d < 2; d++) begin
                if (rs) q[d].delete();
                if (q[d].size() == 0) begin
                    logic [5:0] o;
                    int r;
                    r = $urandom_range(0, 7);
                    fn[d] = fn_pool[$urandom_range(0, 5)];
                    case (r)
                        0: o = LW;
                        1: o = SW;
                        3: o = BEQ;
                        4: o = ADDI;
                        5: o = JMP;
                        6: begin
                            o = 6'($urandom);
                            if (legal(o, 1'b1)) o = 6'b111111;
                        end
                        default: begin
                            o = RT;
                            if (r == 7) fn[d] = 6'($urandom);
                        end
                    endcase
                    op[d] = o;
                    q[d].push_back(0);
                    q[d].push_back(1);
                    if (o == LW) begin
                        q[d].push_back(2);
                        q[d].push_back(3);
                        q[d].push_back(4);
                    end else if (o == SW) begin
                        q[d].push_back(2);
                        q[d].push_back(5);
                    end else if (o == RT) begin
                        q[d].push_back(6);
                        q[d].push_back(7);
                    end else if (o == BEQ) begin
                        q[d].push_back(8);
                    end else if (o == ADDI && d == 0) begin
                        q[d].push_back(9);
                        q[d].push_back(10);
                    end else if (o == JMP && d == 0) begin
                        q[d].push_back(11);
                    end
                end
                z[d] = 1'($urandom_range(0, 1));
                e[d] = q[d].pop_front();
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                logic [21:0] ev;
                ev = model(e[d], op[d], fn[d], z[d], d == 0);
                chk(d == 0 ? "rand_en" : "rand_dis",
                    {10'd0, actv(d)}, {10'd0, ev});
            end
            reset = (cyc == 0) || ($urandom_range(0, 24) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_mips_controller.md
Name: multi_mips_controller

Overview:
- Full multicycle MIPS control unit: Moore main FSM plus ALU decoder.
- Drives the multicycle datapath's mux selects, write enables and ALUControl from IR Opcode/Funct and ALU zero.
- Covers LW, SW, R-type (add/sub/and/or/slt), BEQ, ADDI and J.
- ADDI and J are build-time selectable.
- Unsupported opcodes are flagged and the FSM returns to fetch.

Parameters:
- EN_ADDI, 1, 1 = decode ADDI (opcode 001000); 0 = ADDI treated as illegal.
- EN_JUMP, 1, 1 = decode J (opcode 000010); 0 = J treated as illegal.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; state <= FETCH on the clk edge where reset=1.
- Opcode  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- MemToReg  out  1  1 = register write data from the Data register.
- RegDst  out  1  1 = destination register is rd; 0 = rt.
- IorD  out  1  1 = memory address from ALUOut.
- PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target {PC[31:28], IR[25:0], 2'b00}.
- ALUSrcA  out  1  1 = register A; 0 = PC.
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- IRWrite, MemWrite, RegWrite, Branch, PCWrite  out  1 each  enables.
- PCEn  out  1  PCWrite | (Branch & zero), combinational.
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- IllegalOp  out  1  pulses high in DECODE when Opcode is unsupported.
- State  out  4  current state, for debug and verification.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
- Codes 12-15 are unreachable; if entered, next state = FETCH and all enables = 0.
- Outputs are a pure function of State (Moore), except PCEn and IllegalOp.
- Every output is fully specified in every state. Any output not listed for a state = 0; no x values.
- Reset value of every output = the FETCH decode: IRWrite=1, PCWrite=1, ALUSrcB=01, ALUControl=010, all else 0, State=0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR (LW/SW), EXECUTE (R-type, opcode 000000), BRANCH (BEQ, 000100), ADDIEXEC (ADDI if EN_ADDI), JUMP (J if EN_JUMP), else FETCH.
  - MEMADR -> MEMREAD (LW) or MEMWRITE (SW).
  - MEMREAD -> MEMWB.
  - EXECUTE -> ALUWB.
  - ADDIEXEC -> ADDIWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
- Opcode/Funct are sampled every cycle; IR only changes in FETCH via IRWrite, so they are stable from DECODE onward.
- Per-state outputs:
  - DECODE: ALUSrcB=11, ALUControl=010 (branch-target precompute).
  - MEMADR and ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUControl=010.
  - MEMREAD: IorD=1.
  - MEMWRITE: IorD=1, MemWrite=1.
  - MEMWB: RegDst=0, MemToReg=1, RegWrite=1.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl = funct decode.
  - ALUWB: RegDst=1, MemToReg=0, RegWrite=1.
  - ADDIWB: RegDst=0, MemToReg=0, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, Branch=1.
  - JUMP: PCSrc=10, PCWrite=1.
- Funct decode (EXECUTE only): 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other -> 010. An unknown Funct is not flagged.
- IllegalOp = (State==DECODE) & opcode not in the enabled set. This gives a 1-cycle pulse; the instruction has no side effects (no RegWrite/MemWrite/PCWrite).
- Instruction latency in cycles, FETCH inclusive: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, illegal 2.
- Reset mid-instruction: state is FETCH on the next edge and no further enables from the aborted instruction are asserted after that edge. Reset has priority over all transitions.
- PCEn in BRANCH follows zero combinationally in the same cycle; no registering.

Test Plan:
- Reset held 2 cycles, release, Opcode=100011 (LW) -> State sequence 0,1,2,3,4,0. MemWrite=0 throughout. In state 4: RegWrite=1, MemToReg=1.
- SW (101011) -> states 0,1,2,5,0. MemWrite=1 and IorD=1 only in state 5. RegWrite never 1.
- R-type with Funct=100010, then 101010 -> ALUControl=110, then 111, in EXECUTE. ALUWB has RegDst=1, RegWrite=1. Funct=000000 -> ALUControl=010.
- BEQ (000100) with zero=1 -> PCEn=1 in state 8. With zero=0 -> PCEn=0. Both return to FETCH after 3 cycles.
- J (000010), EN_JUMP=1 -> state 11: PCSrc=10, PCEn=1. Same opcode with EN_JUMP=0 -> IllegalOp=1 in DECODE, next state 0, no enables. Opcode 111111 -> same illegal behaviour.
- Assert reset during MEMREAD of LW -> next state 0. MEMWB is never reached and RegWrite stays 0. ADDI (001000) then gives states 0,1,9,10,0 with ALUSrcB=10 in state 9.
